// File: rtl/prog_loader_pkg.sv
// prog_loader_pkg
// Definitions shared by the program loader and the CPU it feeds: default
// instruction word / address widths and the loader state encoding.
package prog_loader_pkg;

  localparam int DATA_W_DEF = 16;
  localparam int ADDR_W_DEF = 5;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_LOAD  = 3'd1,
    ST_CKSUM = 3'd2,
    ST_READ  = 3'd3,
    ST_CMP   = 3'd4,
    ST_DONE  = 3'd5,
    ST_ERROR = 3'd6
  } state_t;

endpackage

// File: rtl/prog_loader_cksum_acc.sv
// cksum_acc
// Running sum modulo 2**DATA_W.
// Ports:
//   clk, reset   clock, async active-low reset
//   clr          synchronous clear (wins over en)
//   en           add din this cycle
//   din          word to accumulate
//   sum          registered sum
//   sum_next     value sum takes at the next edge
module cksum_acc
  import prog_loader_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEF
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              clr,
  input  logic              en,
  input  logic [DATA_W-1:0] din,
  output logic [DATA_W-1:0] sum,
  output logic [DATA_W-1:0] sum_next
);

  always_comb begin
    sum_next = sum;
    if (clr)
      sum_next = '0;
    else if (en)
      sum_next = sum + din;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset)
      sum <= '0;
    else
      sum <= sum_next;
  end

endmodule

// File: rtl/prog_loader.sv
// prog_loader
// Downloads a program into instruction memory over a valid/ready stream,
// takes a trailing checksum word, reads the memory back and compares sums.
// The CPU is held in reset until the program has been verified.
// Ports:
//   clk, reset            clock, async active-low reset
//   start                 pulse: begin download (IDLE/DONE/ERROR only)
//   in_valid/in_ready     beat handshake; in_data word, in_last final word
//   mem_we/addr/wdata     instruction memory write port (addr also reads)
//   mem_rdata             read data, one cycle after mem_addr
//   cpu_hold              keeps the CPU in reset
//   done / err            verified / failed
//   word_count            words loaded
//
// state | meaning
// IDLE  | waiting for start, CPU held
// LOAD  | accepting instruction beats, writing memory
// CKSUM | accepting the expected checksum word
// READ  | reading memory back, one address per cycle
// CMP   | last read data arrives; sums compared
// DONE  | program verified, CPU released
// ERROR | overflow or checksum mismatch, CPU held
module prog_loader
  import prog_loader_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEF,
  parameter int ADDR_W = ADDR_W_DEF
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_data,
  input  logic              in_last,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic              cpu_hold,
  output logic              done,
  output logic              err,
  output logic [ADDR_W:0]   word_count
);

  state_t            state, state_next;
  logic [ADDR_W-1:0] addr, addr_next;
  logic [ADDR_W:0]   wc_next;
  logic [DATA_W-1:0] exp_sum, exp_next;
  logic              rd_pending, rd_pending_next;
  logic              acc_clr, wr_acc_en;
  logic [DATA_W-1:0] wr_sum, wr_sum_next;
  logic [DATA_W-1:0] rd_sum, rd_sum_next;

  cksum_acc #(.DATA_W(DATA_W)) u_wr_acc (
    .clk      (clk),
    .reset    (reset),
    .clr      (acc_clr),
    .en       (wr_acc_en),
    .din      (in_data),
    .sum      (wr_sum),
    .sum_next (wr_sum_next)
  );

  // Read data lags the address by one cycle, hence the delayed enable.
  cksum_acc #(.DATA_W(DATA_W)) u_rd_acc (
    .clk      (clk),
    .reset    (reset),
    .clr      (acc_clr),
    .en       (rd_pending),
    .din      (mem_rdata),
    .sum      (rd_sum),
    .sum_next (rd_sum_next)
  );

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state      <= ST_IDLE;
      addr       <= '0;
      word_count <= '0;
      exp_sum    <= '0;
      rd_pending <= 1'b0;
    end else begin
      state      <= state_next;
      addr       <= addr_next;
      word_count <= wc_next;
      exp_sum    <= exp_next;
      rd_pending <= rd_pending_next;
    end
  end

  always_comb begin
    state_next      = state;
    addr_next       = addr;
    wc_next         = word_count;
    exp_next        = exp_sum;
    rd_pending_next = 1'b0;
    acc_clr         = 1'b0;
    wr_acc_en       = 1'b0;
    mem_we          = 1'b0;
    mem_addr        = addr;
    mem_wdata       = in_data;

    case (state)
      ST_IDLE, ST_DONE, ST_ERROR: begin
        if (start) begin
          state_next = ST_LOAD;
          addr_next  = '0;
          wc_next    = '0;
          exp_next   = '0;
          acc_clr    = 1'b1;
        end
      end
      ST_LOAD: begin
        if (in_valid) begin
          mem_we    = 1'b1;
          wr_acc_en = 1'b1;
          addr_next = addr + 1'b1;
          wc_next   = word_count + 1'b1;
          if (in_last)
            state_next = ST_CKSUM;
          else if (&addr)
            state_next = ST_ERROR;  // memory full and more words coming
        end
      end
      ST_CKSUM: begin
        if (in_valid) begin
          exp_next   = in_data;
          addr_next  = '0;
          state_next = ST_READ;
        end
      end
      ST_READ: begin
        rd_pending_next = 1'b1;
        addr_next       = addr + 1'b1;
        if ({1'b0, addr} == word_count - 1'b1)
          state_next = ST_CMP;
      end
      ST_CMP: begin
        // rd_sum_next already includes the final read word. Matching the
        // write-side sum as well catches memory that stored a bad word.
        if (rd_sum_next == exp_sum && rd_sum_next == wr_sum)
          state_next = ST_DONE;
        else
          state_next = ST_ERROR;
      end
      default: state_next = ST_IDLE;
    endcase
  end

  assign in_ready = (state == ST_LOAD) || (state == ST_CKSUM);
  assign done     = (state == ST_DONE);
  assign err      = (state == ST_ERROR);
  assign cpu_hold = (state != ST_DONE);

endmodule

// File: tb/tb_prog_loader.sv
module tb_prog_loader;
  localparam int DATA_W = 16;
  localparam int ADDR_W = 5;
  localparam int DEPTH  = 2 ** ADDR_W;

  logic              clk = 1'b0;
  logic              reset = 1'b0;
  logic              start = 1'b0;
  logic              in_valid = 1'b0;
  logic              in_ready;
  logic [DATA_W-1:0] in_data = '0;
  logic              in_last = 1'b0;
  logic              mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_wdata;
  logic [DATA_W-1:0] mem_rdata = '0;
  logic              cpu_hold, done, err;
  logic [ADDR_W:0]   word_count;

  prog_loader #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) dut (
    .clk        (clk),
    .reset      (reset),
    .start      (start),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .in_data    (in_data),
    .in_last    (in_last),
    .mem_we     (mem_we),
    .mem_addr   (mem_addr),
    .mem_wdata  (mem_wdata),
    .mem_rdata  (mem_rdata),
    .cpu_hold   (cpu_hold),
    .done       (done),
    .err        (err),
    .word_count (word_count)
  );

  always #5 clk = ~clk;

  logic [DATA_W-1:0] mem [DEPTH];
  always @(posedge clk) begin
    if (mem_we) mem[mem_addr] <= mem_wdata;
    mem_rdata <= mem[mem_addr];
  end

  int n_pass  = 0;
  int n_total = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  // Scoreboard of expected memory writes {addr, data}.
  logic [ADDR_W+DATA_W-1:0] wq [$];
  logic [ADDR_W-1:0]        exp_addr;
  logic [DATA_W-1:0]        exp_sum;

  always @(negedge clk) begin
    if (reset && mem_we) begin
      if (wq.size() == 0) begin
        chk("unexpected_write", {27'd0, mem_addr}, 32'hFFFF_FFFF);
      end else begin
        logic [ADDR_W+DATA_W-1:0] e;
        e = wq.pop_front();
        chk("write_addr", {27'd0, mem_addr}, {27'd0, e[ADDR_W+DATA_W-1:DATA_W]});
        chk("write_data", {16'd0, mem_wdata}, {16'd0, e[DATA_W-1:0]});
      end
    end
  end

  task automatic cyc();
    @(posedge clk); #1;
  endtask

  task automatic pulse_start();
    start = 1'b1; cyc(); start = 1'b0;
    exp_addr = '0; exp_sum = '0;
  endtask

  task automatic send_beat(input logic [DATA_W-1:0] d, input logic last);
    wq.push_back({exp_addr, d});
    exp_addr = exp_addr + 1'b1;
    exp_sum  = exp_sum + d;
    in_valid = 1'b1; in_data = d; in_last = last;
    cyc();
    in_valid = 1'b0; in_last = 1'b0;
  endtask

  task automatic send_cksum(input logic [DATA_W-1:0] c);
    in_valid = 1'b1; in_data = c; in_last = 1'b0;
    cyc();
    in_valid = 1'b0;
  endtask

  task automatic wait_end(input string tag);
    int n = 0;
    while (!(done || err) && n < 100) begin cyc(); n++; end
    chk(tag, {31'd0, (n < 100)}, 32'd1);
  endtask

  task automatic chk_reset_vals(input string tag);
    chk({tag, "_hold"},  {31'd0, cpu_hold}, 32'd1);
    chk({tag, "_done"},  {31'd0, done},     32'd0);
    chk({tag, "_err"},   {31'd0, err},      32'd0);
    chk({tag, "_ready"}, {31'd0, in_ready}, 32'd0);
    chk({tag, "_we"},    {31'd0, mem_we},   32'd0);
    chk({tag, "_addr"},  {27'd0, mem_addr}, 32'd0);
    chk({tag, "_wc"},    {26'd0, word_count}, 32'd0);
  endtask

  initial begin
    logic [DATA_W-1:0] d;
    int                got;
    exp_addr = '0; exp_sum = '0;

    // Reset state
    #2; chk_reset_vals("rst");
    cyc(); cyc(); reset = 1'b1; cyc();
    chk("idle_hold", {31'd0, cpu_hold}, 32'd1);

    // Good three-word program; a start during LOAD must be ignored
    pulse_start();
    chk("load_ready", {31'd0, in_ready}, 32'd1);
    chk("load_hold",  {31'd0, cpu_hold}, 32'd1);
    send_beat(16'h1234, 1'b0);
    start = 1'b1;
    send_beat(16'h0001, 1'b0);
    start = 1'b0;
    send_beat(16'h00FF, 1'b1);
    chk("cksum_ready", {31'd0, in_ready}, 32'd1);
    chk("cksum_wc",    {26'd0, word_count}, 32'd3);
    send_cksum(16'h1334);
    chk("read_ready", {31'd0, in_ready}, 32'd0);
    wait_end("t1_timeout");
    chk("t1_done", {31'd0, done},     32'd1);
    chk("t1_err",  {31'd0, err},      32'd0);
    chk("t1_hold", {31'd0, cpu_hold}, 32'd0);
    chk("t1_wc",   {26'd0, word_count}, 32'd3);
    chk("t1_mem0", {16'd0, mem[0]}, 32'h1234);
    chk("t1_mem2", {16'd0, mem[2]}, 32'h00FF);

    // Restart from DONE, same program with a bad checksum
    pulse_start();
    chk("rs_hold",  {31'd0, cpu_hold}, 32'd1);
    chk("rs_wc",    {26'd0, word_count}, 32'd0);
    chk("rs_ready", {31'd0, in_ready}, 32'd1);
    chk("rs_done",  {31'd0, done}, 32'd0);
    send_beat(16'h1234, 1'b0);
    send_beat(16'h0001, 1'b0);
    send_beat(16'h00FF, 1'b1);
    send_cksum(16'h1335);
    wait_end("t2_timeout");
    chk("t2_err",  {31'd0, err},      32'd1);
    chk("t2_hold", {31'd0, cpu_hold}, 32'd1);
    chk("t2_done", {31'd0, done},     32'd0);

    // Overflow: DEPTH beats without in_last
    pulse_start();
    for (int i = 0; i < DEPTH; i++) begin
      chk("ovf_ready", {31'd0, in_ready}, 32'd1);
      send_beat(16'hA000 + 16'(i), 1'b0);
    end
    chk("ovf_err",   {31'd0, err}, 32'd1);
    chk("ovf_wc",    {26'd0, word_count}, DEPTH);
    in_valid = 1'b1; in_data = 16'hDEAD;
    for (int i = 0; i < 3; i++) begin
      chk("ovf_noready", {31'd0, in_ready}, 32'd0);
      cyc();
    end
    in_valid = 1'b0;
    chk("ovf_mem31", {16'd0, mem[31]}, 32'hA01F);

    // Random in_valid gaps: writes only on handshakes, contiguous addresses
    pulse_start();
    got = 0;
    while (got < 6) begin
      if ($urandom_range(0, 1) == 1) begin
        d = 16'($urandom);
        got++;
        send_beat(d, got == 6);
      end else begin
        in_valid = 1'b0; in_data = 16'($urandom);
        cyc();
      end
    end
    chk("rnd_wc", {26'd0, word_count}, 32'd6);
    send_cksum(exp_sum);
    wait_end("t4_timeout");
    chk("rnd_done", {31'd0, done}, 32'd1);

    // Full-depth legal program
    pulse_start();
    for (int i = 0; i < DEPTH; i++) send_beat(16'($urandom), i == DEPTH - 1);
    chk("full_ready", {31'd0, in_ready}, 32'd1);
    chk("full_wc",    {26'd0, word_count}, DEPTH);
    send_cksum(exp_sum);
    wait_end("full_timeout");
    chk("full_done", {31'd0, done}, 32'd1);
    chk("full_wc2",  {26'd0, word_count}, DEPTH);

    // Reset in the middle of a download
    pulse_start();
    send_beat(16'h1111, 1'b0);
    send_beat(16'h2222, 1'b0);
    #2 reset = 1'b0;
    #1 chk_reset_vals("mid");
    cyc(); reset = 1'b1; cyc();
    chk("mid_idle_ready", {31'd0, in_ready}, 32'd0);
    pulse_start();
    send_beat(16'h0010, 1'b0);
    send_beat(16'h0020, 1'b0);
    send_beat(16'h0030, 1'b0);
    send_beat(16'h0040, 1'b1);
    send_cksum(16'h00A0);
    wait_end("mid_timeout");
    chk("mid_done", {31'd0, done}, 32'd1);
    chk("mid_wc",   {26'd0, word_count}, 32'd4);
    chk("mid_mem0", {16'd0, mem[0]}, 32'h0010);

    cyc();
    chk("wq_empty", wq.size(), 32'd0);
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/prog_loader.md
PROG_LOADER -- requirements
Module: prog_loader

Interface
REQ-001 Parameter DATA_W, 16, instruction word width.
REQ-002 Parameter ADDR_W, 5, instruction memory address width; DEPTH = 2**ADDR_W.
REQ-003 The block SHALL have exactly one clock; reset is asynchronous and active-low.
REQ-004 clk  input  1  sole clock, rising edge.
REQ-005 reset  input  1  asynchronous, active-low reset.
REQ-006 start  input  1  one-cycle pulse that begins a program download.
REQ-007 in_valid  input  1  download beat valid.
REQ-008 in_ready  output  1  loader accepts a beat this cycle.
REQ-009 in_data  input  DATA_W  instruction word, or checksum word.
REQ-010 in_last  input  1  marks the final instruction beat.
REQ-011 mem_we  output  1  instruction memory write strobe.
REQ-012 mem_addr  output  ADDR_W  instruction memory address for both write and read.
REQ-013 mem_wdata  output  DATA_W  instruction memory write data.
REQ-014 mem_rdata  input  DATA_W  instruction memory read data, valid one cycle after mem_addr.
REQ-015 cpu_hold  output  1  held high to keep the CPU in reset while the program is loaded.
REQ-016 done  output  1  program loaded and verified.
REQ-017 err  output  1  download failed.
REQ-018 word_count  output  ADDR_W+1  number of instruction words loaded.

Function
REQ-019 The block SHALL implement these states: IDLE, LOAD, CKSUM, READ, CMP, DONE, ERROR.
REQ-020 IDLE: start=1 SHALL enter LOAD, clear the address, sum and word_count, and raise cpu_hold.
REQ-021 LOAD: in_ready=1; each handshake (in_valid & in_ready) SHALL write in_data at mem_addr in the same cycle and increment the address and word_count.
REQ-022 LOAD: a handshake with in_last=1 SHALL go to CKSUM.
REQ-023 LOAD overflow: a handshake at address DEPTH-1 with in_last=0 SHALL write the word and then go to ERROR.
REQ-024 CKSUM: in_ready=1; one handshake SHALL capture in_data as the expected checksum (no memory write) and then go to READ.
REQ-025 READ: the block SHALL drive mem_addr from 0 to word_count-1, one address per cycle.
REQ-026 READ: mem_rdata SHALL be accumulated one cycle after each address is driven, as a sum modulo 2**DATA_W.
REQ-027 CMP: entered one cycle after the final read, so that the last rdata is accumulated.
REQ-028 CMP: if the readback sum equals the expected checksum, the block SHALL go to DONE; otherwise it SHALL go to ERROR.
REQ-029 DONE: done=1 and cpu_hold=0; start=1 SHALL restart the download as in IDLE (cpu_hold=1 on the next cycle).
REQ-030 ERROR: err=1 and cpu_hold=1; start=1 SHALL restart as in IDLE.
REQ-031 In LOAD, CKSUM, READ and CMP, start SHALL be ignored.
REQ-032 in_ready SHALL be 0 outside LOAD and CKSUM; in_valid without handshake SHALL have no effect.
REQ-033 mem_we SHALL be 1 only in LOAD handshake cycles.
REQ-034 done, err, cpu_hold and in_ready SHALL be pure functions of the registered state.
REQ-035 An in_last beat at address DEPTH-1 SHALL be a legal full program (word_count=DEPTH).

Reset
REQ-036 On reset low, the block SHALL immediately enter IDLE with cpu_hold=1, done=0, err=0, in_ready=0, mem_we=0, mem_addr=0, word_count=0, and sum/checksum=0.
REQ-037 Reset mid-download SHALL abort the download; memory contents are then undefined, and a new start is required.

Structure
REQ-038 The state encoding and the DATA_W/ADDR_W defaults SHALL reside in a shared package used by the CPU and the loader.
REQ-039 The block SHALL be a single module plus one sub-module, cksum_acc (clear, enable, data in, modulo-2**DATA_W sum out), instantiated twice: once for the write path and once for readback.

Verification
REQ-040 start; beats 0x1234, 0x0001, 0x00FF (last); checksum 0x1334 -> memory words 0 to 2 written, word_count=3, done=1, cpu_hold=0.
REQ-041 Same program with checksum 0x1335 -> err=1, cpu_hold=1, done=0.
REQ-042 32 beats with no in_last -> 32 writes, err=1 after the 32nd beat, no further in_ready.
REQ-043 in_valid toggled randomly during LOAD -> writes occur only on handshakes, with addresses contiguous from 0.
REQ-044 reset asserted after 2 of 4 beats -> all outputs at reset values immediately; a new start reloads from address 0.
REQ-045 In DONE, start pulse -> cpu_hold=1 on the next cycle, word_count=0, download accepted again.
